// File: rtl/input_conditioner.sv
// Per-bit 2-flop synchroniser and stability-counter debouncer for board switches/buttons.
// Emits registered rise/fall pulses and a sticky change flag for software polling.
module input_conditioner #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             changed_clr,
  output logic [WIDTH-1:0] stable_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    cnt_d    = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]    = '0;
        stable_d[i] = s2_q[i];
        rise_d[i]   = s2_q[i];
        fall_d[i]   = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    // A new event on the same edge as a clear must win so it is never lost.
    if ((|rise_d) || (|fall_d)) begin
      changed_d = 1'b1;
    end else if (changed_clr) begin
      changed_d = 1'b0;
    end else begin
      changed_d = changed_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= raw_in;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign stable_out = stable_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign changed    = changed_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with DEBOUNCE_CYCLES=4: directed vectors push
// expected pulse events; a negedge monitor pops and compares whenever a pulse appears.
module tb_input_conditioner;

  localparam int W = 16;
  localparam int D = 4;
  localparam int LAT = D + 2;  // drive at negedge of cycle N -> pulse visible at cycle N+LAT

  typedef struct {
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] stable;
    int           cyc;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] raw_in;
  logic         changed_clr;
  logic [W-1:0] stable_out, rise_pulse, fall_pulse;
  logic         changed;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  ev_t exp_q[$];

  input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .changed_clr(changed_clr),
    .stable_out (stable_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .changed    (changed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input logic [W-1:0] r, input logic [W-1:0] f,
                           input logic [W-1:0] s, input int c);
    ev_t e;
    e.rise = r; e.fall = f; e.stable = s; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Drive a new pin pattern and record the event it must produce.
  task automatic drive(input logic [W-1:0] v, input logic [W-1:0] r,
                       input logic [W-1:0] f, input logic [W-1:0] s);
    raw_in = v;
    expect_ev(r, f, s, cyc + LAT);
    tick(LAT + 2);
  endtask

  // Monitor: any pulse activity is an output event to be matched against the scoreboard.
  always @(negedge clk) begin
    if ((rise_pulse | fall_pulse) != '0) begin
      chk("pulse_exclusive", 32'(rise_pulse & fall_pulse), 32'h0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {rise_pulse, fall_pulse}, 32'h0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("ev_rise",   32'(rise_pulse), 32'(e.rise));
        chk("ev_fall",   32'(fall_pulse), 32'(e.fall));
        chk("ev_stable", 32'(stable_out), 32'(e.stable));
        chk("ev_cycle",  32'(cyc),        32'(e.cyc));
      end
    end
  end

  initial begin
    int n;
    rst = 1'b0; raw_in = 16'hFFFF; changed_clr = 1'b0;

    // 1. reset with pins high, then release
    tick(3);
    chk("rst_stable",  32'(stable_out), 32'h0);
    chk("rst_rise",    32'(rise_pulse), 32'h0);
    chk("rst_fall",    32'(fall_pulse), 32'h0);
    chk("rst_changed", 32'(changed),    32'h0);
    rst = 1'b1;
    n = cyc;
    expect_ev(16'hFFFF, 16'h0, 16'hFFFF, n + LAT);
    tick(LAT - 1);
    chk("t1_not_early", 32'(stable_out), 32'h0);
    tick(2);
    chk("t1_pulse_one_cycle", 32'(rise_pulse), 32'h0);
    chk("t1_changed", 32'(changed), 32'h1);
    changed_clr = 1'b1; tick(1); changed_clr = 1'b0;
    chk("t1_changed_clr", 32'(changed), 32'h0);

    // 2. clean press/release on bit 3
    drive(16'h0000, 16'h0, 16'hFFFF, 16'h0000);
    raw_in = 16'h0008;
    expect_ev(16'h0008, 16'h0, 16'h0008, cyc + LAT);
    tick(LAT - 1);
    chk("t2_not_early", 32'(stable_out), 32'h0);
    tick(3);
    drive(16'h0000, 16'h0, 16'h0008, 16'h0000);

    // 3. bounce on bit 0: levels held 2 cycles never qualify
    for (int k = 0; k < 4; k++) begin
      raw_in = (k % 2 == 0) ? 16'h0001 : 16'h0000;
      tick(2);
    end
    chk("t3_bounce_stable", 32'(stable_out), 32'h0);
    drive(16'h0001, 16'h0001, 16'h0, 16'h0001);
    drive(16'h0000, 16'h0, 16'h0001, 16'h0000);

    // 4. reset while bit 7 is mid-qualification (counter == 2)
    raw_in = 16'h0080;
    tick(4);
    rst = 1'b0; tick(1);
    chk("t4_rst_stable", 32'(stable_out), 32'h0);
    rst = 1'b1;
    n = cyc;
    expect_ev(16'h0080, 16'h0, 16'h0080, n + LAT);
    tick(LAT - 1);
    chk("t4_restart", 32'(stable_out), 32'h0);
    tick(3);
    drive(16'h0000, 16'h0, 16'h0080, 16'h0000);

    // 5. clear on the same edge as a new rise on bit 9
    chk("t5_changed_set", 32'(changed), 32'h1);
    raw_in = 16'h0200;
    n = cyc;
    expect_ev(16'h0200, 16'h0, 16'h0200, n + LAT);
    tick(LAT - 1);
    changed_clr = 1'b1; tick(1); changed_clr = 1'b0;
    chk("t5_set_wins", 32'(changed), 32'h1);
    tick(2);
    changed_clr = 1'b1; tick(1); changed_clr = 1'b0;
    chk("t5_clr_no_event", 32'(changed), 32'h0);
    tick(1);
    chk("t5_clr_holds", 32'(changed), 32'h0);
    drive(16'h0000, 16'h0, 16'h0200, 16'h0000);

    // 6. simultaneous multi-bit rise
    changed_clr = 1'b1; tick(1); changed_clr = 1'b0;
    drive(16'hA5A5, 16'hA5A5, 16'h0, 16'hA5A5);
    chk("t6_stable", 32'(stable_out), 32'hA5A5);
    chk("t6_changed", 32'(changed), 32'h1);

    tick(3);
    chk("all_events_seen", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Sits directly upstream of the switches bus peripheral, between the raw board pins (slide switches and push buttons) and that peripheral's `switches`/`btns` inputs.
- Per bit, it synchronises the asynchronous pin, debounces it with a stability counter, and produces a clean level.
- It also produces single-cycle rise/fall pulses and a sticky "something changed" flag that the FSM can poll through the switches peripheral.
- One instance serves the 16 switches and a second serves the 16 buttons.

Parameters:
- WIDTH, 16, number of independent input bits.
- DEBOUNCE_CYCLES, 1000000, number of consecutive clock cycles the synchronised input must differ from the current stable level before the stable level flips (10 ms at 100 MHz). Legal range is ≥1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width. Derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low: state clears on a rising clk edge while rst==0.
- raw_in  input  WIDTH  asynchronous pin levels.
- changed_clr  input  1  clears the sticky changed flag; single-cycle pulse from the consumer.
- stable_out  output  WIDTH  debounced levels; connects to the switches peripheral.
- rise_pulse  output  WIDTH  bit i is high for exactly 1 cycle when stable_out[i] goes 0→1.
- fall_pulse  output  WIDTH  bit i is high for exactly 1 cycle when stable_out[i] goes 1→0.
- changed  output  1  sticky; set by any rise or fall pulse, cleared by changed_clr.

Behaviour:
- Reset (rst==0 at a clk edge):
  - sync stages, counters, stable_out, rise_pulse, fall_pulse and changed all go to 0.
  - A partially debounced transition is discarded.
  - After reset, a pin already held high re-qualifies from scratch and produces a rise_pulse.
- Synchroniser: per bit, two flops s1←raw_in, s2←s1. No logic between them. s2 is the only value the debounce logic uses.
- Debounce, per bit i, evaluated every edge while rst==1:
  - s2==stable: counter←0.
  - s2!=stable and counter<DEBOUNCE_CYCLES-1: counter←counter+1.
  - s2!=stable and counter==DEBOUNCE_CYCLES-1: stable←s2, counter←0, and the matching pulse register←1 on the same edge.
- Pulses:
  - rise_pulse/fall_pulse are registered and are high during exactly the cycle in which stable_out first shows the new value; they are 0 otherwise.
  - At most one of rise_pulse[i] or fall_pulse[i] is high in any cycle.
- Glitch rejection: if s2 returns to the stable value before the count completes, the counter clears to 0. Any bounce restarts qualification from zero.
- Latency: raw_in[i] changes and is held. Counting the first clk edge that samples the new value as edge 0, stable_out[i] changes on edge DEBOUNCE_CYCLES+1 and the pulse is high for the following cycle.
  - DEBOUNCE_CYCLES=1 gives a flip on edge 2, i.e. a plain 2-flop synchroniser plus edge detect.
- Independence: bits have separate counters; simultaneous transitions on several bits produce simultaneous pulses on those bits.
- changed flag:
  - changed←1 on any edge where any rise_pulse or fall_pulse bit is being set.
  - Otherwise changed←0 if changed_clr==1, else it holds.
  - If set and clear happen on the same edge, set wins, so no event is lost.
- Counter width: the counter never exceeds DEBOUNCE_CYCLES-1, so it has no wrap-around. CNT_W must hold DEBOUNCE_CYCLES-1 without truncation.
- No combinational path from any input to any output; every output is a flop.

Test Plan (run with DEBOUNCE_CYCLES=4, WIDTH=16):
1. Reset release: hold rst=0 for 3 edges with raw_in=16'hFFFF, then raise rst and keep raw_in=16'hFFFF → outputs stay 0 through reset. On edge 5 after release, stable_out=16'hFFFF. On the next cycle rise_pulse=16'hFFFF for exactly 1 cycle, and changed=1.
2. Clean press: raw_in[3] 0→1 and held → stable_out[3] flips on edge 5 (edge 0 = first sampling edge). rise_pulse[3]=1 for 1 cycle, all other pulse bits stay 0. Release → fall_pulse[3] after the same latency.
3. Bounce: raw_in[0] toggles 1,0,1,0 with each level held 2 cycles, then held at 1 → no pulse during the bouncing; exactly one rise_pulse[0] occurs 5 edges after the final stable sampling edge.
4. Reset mid-qualification: raw_in[7]=1 held; assert rst=0 on the edge where counter==2 for 1 edge, then release → stable_out[7] stays 0 at the moment of reset, and qualification restarts from 0 (full 5-edge latency after release).
5. Sticky flag race: changed=1, then pulse changed_clr on the same edge a new rise_pulse is generated on bit 9 → changed remains 1. A later changed_clr with no event → changed=0.
6. Multi-bit: raw_in 16'h0000→16'hA5A5 in one cycle → rise_pulse=16'hA5A5 in a single cycle, and stable_out=16'hA5A5.
